// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: func3 encodings, LSU state, lane helpers.
// Constants only; no logic, so no latency or backpressure of its own.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  // func3[1:0] encodes the access size for both loads and stores
  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = 4'b0011 << off;
      default: lane_be = 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the byte/half at the given offset of a word and sign/zero-extends it.
// Purely combinational, zero latency, no backpressure.
module load_extend
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [2:0]        i_func3,
  input  logic [1:0]        i_offset,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_offset, 3'b000} +: 8];
    w_half = i_word[{i_offset[1], 4'b0000} +: 16];
    case (i_func3)
      F3_LB:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{(DATA_W-16){w_half[15]}}, w_half};
      F3_LBU:  o_data = {{(DATA_W-8){1'b0}}, w_byte};
      F3_LHU:  o_data = {{(DATA_W-16){1'b0}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_ctrl.sv
// Sequences one core load/store onto a valid/ready memory port, stalling the core meanwhile.
// Latency: 4 cycles minimum (IDLE-REQ-WAIT-DONE); +1 per cycle of req_ready low or rsp_valid absent.
module load_store_ctrl
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic              lsu_fault,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [3:0]        req_be,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata
);

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  logic              w_access;
  logic              w_illegal;
  logic              w_start;
  logic [DATA_W-1:0] w_wdata;
  logic              r_req_valid;
  logic              r_req_we;
  logic [ADDR_W-1:0] r_req_addr;
  logic [3:0]        r_req_be;
  logic [DATA_W-1:0] r_req_wdata;
  logic [2:0]        r_func3;
  logic [1:0]        r_off;
  logic [DATA_W-1:0] r_rdata;

  always_comb begin
    w_access  = mem_read | mem_write;
    w_illegal = 1'b0;
    if (mem_read && mem_write)
      w_illegal = 1'b1;
    else if (mem_read && (func3[1:0] == 2'b11 || func3 == 3'b110))
      w_illegal = 1'b1;
    else if (mem_write && func3 > F3_SW)
      w_illegal = 1'b1;
    else if (func3[1:0] == 2'b01 && addr[0])
      w_illegal = 1'b1;
    else if (func3[1:0] == 2'b10 && addr[1:0] != 2'b00)
      w_illegal = 1'b1;
    w_start = (r_state == IDLE) && w_access && !w_illegal;
  end

  always_comb begin
    case (func3[1:0])
      2'b00:   w_wdata = {4{store_data[7:0]}};
      2'b01:   w_wdata = {2{store_data[15:0]}};
      default: w_wdata = store_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start)   w_next = REQ;
      REQ:     if (req_ready) w_next = WAIT;
      WAIT:    if (rsp_valid) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    lsu_fault = 1'b0;
    case (r_state)
      IDLE: begin
        stall     = w_start;
        lsu_fault = w_access && w_illegal;
      end
      REQ, WAIT: stall = 1'b1;
      default:   stall = 1'b0;
    endcase
  end

  // Request fields only load in IDLE, so they stay frozen while REQ waits for ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_valid <= 1'b0;
      r_req_we    <= 1'b0;
      r_req_addr  <= '0;
      r_req_be    <= '0;
      r_req_wdata <= '0;
      r_func3     <= '0;
      r_off       <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          r_req_valid <= 1'b1;
          r_req_we    <= mem_write;
          r_req_addr  <= {addr[ADDR_W-1:2], 2'b00};
          r_req_be    <= lane_be(func3, addr[1:0]);
          r_req_wdata <= w_wdata;
          r_func3     <= func3;
          r_off       <= addr[1:0];
        end
        REQ:  if (req_ready) r_req_valid <= 1'b0;
        WAIT: if (rsp_valid && !r_req_we) r_rdata <= rsp_rdata;
        default: ;
      endcase
    end
  end

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .i_word   (r_rdata),
    .i_func3  (r_func3),
    .i_offset (r_off),
    .o_data   (load_data)
  );

  assign req_valid = r_req_valid;
  assign req_we    = r_req_we;
  assign req_addr  = r_req_addr;
  assign req_be    = r_req_be;
  assign req_wdata = r_req_wdata;

endmodule
